// File: rtl/alu_sequencer.sv
// Four-phase instruction sequencer (IDLE/DECODE/EXEC/WB) that steers an external
// ALU and issues one register-file or memory write per accepted instruction.
module alu_sequencer #(
  parameter int WIDTH   = 8,
  parameter int IWIDTH  = 8,
  parameter int SOURCES = 4,
  localparam int SW     = (SOURCES > 1) ? $clog2(SOURCES) : 1,
  localparam int IW     = IWIDTH + 2 * SW + 4 + WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [IW-1:0]     instr,
  output logic              instr_ready,
  output logic [IWIDTH-1:0] op_code,
  output logic [SW-1:0]     source1_choice,
  output logic [SW-1:0]     source2_choice,
  output logic [WIDTH-1:0]  imm_a,
  output logic [WIDTH-1:0]  imm_b,
  output logic              alu_c_in,
  output logic              alu_b_in,
  input  logic [WIDTH-1:0]  alu_out,
  input  logic              alu_c_out,
  input  logic              alu_b_out,
  input  logic              alu_flag_valid,
  output logic              rf_we,
  output logic              mem_we,
  output logic [3:0]        wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic              done,
  output logic              illegal
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DECODE = 2'd1;
  localparam logic [1:0] EXEC   = 2'd2;
  localparam logic [1:0] WB     = 2'd3;

  localparam logic [IWIDTH-1:0] OP_CARRY  = IWIDTH'(8'h07);
  localparam logic [IWIDTH-1:0] OP_BORROW = IWIDTH'(8'h08);
  localparam logic [IWIDTH-1:0] OP_RF_MAX = IWIDTH'(8'h11);
  localparam logic [IWIDTH-1:0] OP_RF_X0  = IWIDTH'(8'h1F);
  localparam logic [IWIDTH-1:0] OP_RF_X1  = IWIDTH'(8'h20);
  localparam logic [IWIDTH-1:0] OP_MEM_LO = IWIDTH'(8'h1B);
  localparam logic [IWIDTH-1:0] OP_MEM_HI = IWIDTH'(8'h1E);

  logic [1:0]        state_r;
  logic [3:0]        dst_r;
  logic [IWIDTH-1:0] f_op_s;
  logic [SW-1:0]     f_src1_s;
  logic [SW-1:0]     f_src2_s;
  logic [3:0]        f_dst_s;
  logic [WIDTH-1:0]  f_imm_s;

  function automatic logic is_rf_op(input logic [IWIDTH-1:0] op);
    return (op <= OP_RF_MAX) || (op == OP_RF_X0) || (op == OP_RF_X1);
  endfunction

  function automatic logic is_mem_op(input logic [IWIDTH-1:0] op);
    return (op >= OP_MEM_LO) && (op <= OP_MEM_HI);
  endfunction

  assign f_op_s   = instr[IW-1 -: IWIDTH];
  assign f_src1_s = instr[2*SW+4+WIDTH-1 -: SW];
  assign f_src2_s = instr[SW+4+WIDTH-1 -: SW];
  assign f_dst_s  = instr[4+WIDTH-1 -: 4];
  assign f_imm_s  = instr[WIDTH-1:0];

  assign instr_ready = (state_r == IDLE);

  // Sequencer state, latched instruction fields, flags and write-back strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      dst_r          <= 4'd0;
      op_code        <= '0;
      source1_choice <= '0;
      source2_choice <= '0;
      imm_a          <= '0;
      imm_b          <= '0;
      alu_c_in       <= 1'b0;
      alu_b_in       <= 1'b0;
      wr_addr        <= 4'd0;
      wr_data        <= '0;
      rf_we          <= 1'b0;
      mem_we         <= 1'b0;
      done           <= 1'b0;
      illegal        <= 1'b0;
    end else begin
      rf_we  <= 1'b0;
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (instr_valid) begin
            op_code        <= f_op_s;
            source1_choice <= f_src1_s;
            source2_choice <= f_src2_s;
            imm_a          <= f_imm_s;
            imm_b          <= f_imm_s;
            dst_r          <= f_dst_s;
            state_r        <= DECODE;
          end
        end
        DECODE: state_r <= EXEC;
        EXEC: begin
          wr_data <= alu_out;
          wr_addr <= dst_r;
          if (alu_flag_valid && (op_code == OP_CARRY)) alu_c_in <= alu_c_out;
          if (alu_flag_valid && (op_code == OP_BORROW)) alu_b_in <= alu_b_out;
          // Strobes are registered here so they are high for exactly the WB cycle
          rf_we  <= is_rf_op(op_code);
          mem_we <= is_mem_op(op_code);
          done   <= 1'b1;
          if (!is_rf_op(op_code) && !is_mem_op(op_code)) illegal <= 1'b1;
          state_r <= WB;
        end
        WB:      state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, ALU data width.
REQ-002 SHALL have parameter IWIDTH, default 8, op_code width.
REQ-003 SHALL have parameter SOURCES, default 4, ALU operand sources; choice width SW = clog2(SOURCES).
REQ-004 SHALL have clk  input  1  single clock; all state changes on the rising edge.
REQ-005 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have instr_valid  input  1  instruction offered.
REQ-007 SHALL have instr  input  IWIDTH+2*SW+4+WIDTH (24 at defaults)  {op, src1, src2, dst[3:0], imm}, MSB first.
REQ-008 SHALL have instr_ready  output  1  sequencer can accept an instruction.
REQ-009 SHALL have op_code  output  IWIDTH  ALU op code.
REQ-010 SHALL have source1_choice and source2_choice  output  SW each  ALU operand selects.
REQ-011 SHALL have imm_a and imm_b  output  WIDTH each  both driven from the imm field.
REQ-012 SHALL have alu_c_in and alu_b_in  output  1 each  registered carry and borrow flags.
REQ-013 SHALL have alu_out  input  WIDTH; alu_c_out, alu_b_out, alu_flag_valid  input  1 each  ALU results.
REQ-014 SHALL have rf_we and mem_we  output  1 each  register-file and word-memory write strobes.
REQ-015 SHALL have wr_addr  output  4 and wr_data  output  WIDTH  write address and data.
REQ-016 SHALL have done  output  1  one-cycle completion pulse; illegal  output  1  sticky illegal-op flag.

Function
REQ-017 SHALL implement states IDLE, DECODE, EXEC, WB.
REQ-018 SHALL assert instr_ready only in IDLE.
REQ-019 SHALL, on a rising edge with instr_valid and instr_ready both high, latch all instr fields and go IDLE->DECODE.
REQ-020 SHALL drive op_code, source choices and imm_a/imm_b from the latched fields from DECODE onwards, holding them until the next accept.
REQ-021 SHALL go DECODE->EXEC unconditionally; DECODE is an operand-settling cycle.
REQ-022 SHALL, at the edge that leaves EXEC, capture alu_out into wr_data and dst into wr_addr, then go to WB.
REQ-023 SHALL, at that same edge, load carry from alu_c_out only if op==0x07 and alu_flag_valid==1.
REQ-024 SHALL, at that same edge, load borrow from alu_b_out only if op==0x08 and alu_flag_valid==1; otherwise both flags hold.
REQ-025 SHALL, in WB, assert exactly one strobe for one cycle: mem_we for op 0x1B, 0x1C, 0x1D, 0x1E; rf_we for ops 0x00-0x11, 0x1F, 0x20.
REQ-026 SHALL treat any other op as illegal: no strobe in WB, illegal set to 1 at the WB edge and held until reset, flags unchanged.
REQ-027 SHALL assert done during WB for every instruction, legal or illegal, then go WB->IDLE.
REQ-028 SHALL give fixed latency: accept at edge E0, strobe and done high between E2 and E3, instr_ready high again after E3; throughput one instruction per 4 cycles.
REQ-029 SHALL ignore instr_valid outside IDLE; the instruction stays unaccepted.
REQ-030 SHALL keep rf_we, mem_we and done low outside WB.

Reset
REQ-031 SHALL, while rst_n is low, force state IDLE and clear op_code, source choices, imm_a/b, alu_c_in, alu_b_in, wr_addr, wr_data, rf_we, mem_we, done and illegal to 0.
REQ-032 SHALL, when reset asserts mid-instruction, abort immediately with no strobe or done; instr_ready=1 on the first edge after release.

Verification
REQ-033 SHALL cover: instr op=0x07 src1=0 src2=3 dst=5 imm=0x01, ALU returns 0x00 with c_out=1, flag_valid=1 -> rf_we=1, wr_addr=5, wr_data=0x00 at E2-E3; alu_c_in=1 afterwards.
REQ-034 SHALL cover: op=0x1D dst=2, alu_out=0xA5 -> mem_we=1, rf_we=0, wr_addr=2, wr_data=0xA5; done one cycle.
REQ-035 SHALL cover: op=0x15 -> no strobe, done=1, illegal=1 stays set through a following legal op=0x00.
REQ-036 SHALL cover: instr_valid held high through DECODE/EXEC/WB -> second instruction accepted only at E3+1 edge; 4-cycle spacing verified.
REQ-037 SHALL cover: rst_n low during EXEC -> no rf_we/mem_we/done; all outputs 0; instr_ready=1 after release.
REQ-038 SHALL cover: op=0x08 with alu_b_out=1 flag_valid=0 -> alu_b_in unchanged (0).
